// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } pc_seq_state_e;

    localparam logic [31:0] PC_RESET_VALUE = 32'h0000_0000;
    localparam logic [31:0] PC_INCR        = 32'd4;

    // Signed word offset converted to a byte displacement.
    function automatic logic [31:0] offset_to_bytes(input logic [7:0] offset);
        return {{22{offset[7]}}, offset, 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between the core datapath/memories (master) and the PC sequencer (slave).
interface pc_sequencer_if;
    logic        IMEM_BUSYWAIT;
    logic        DMEM_BUSYWAIT;
    logic        JUMP_EN;
    logic        BRANCH_EN;
    logic        BNE_EN;
    logic        ZERO;
    logic [7:0]  OFFSET;
    logic [31:0] PC;
    logic        IMEM_READ;
    logic        INSTR_VALID;
    logic        STALL;

    modport master (
        output IMEM_BUSYWAIT, DMEM_BUSYWAIT, JUMP_EN, BRANCH_EN, BNE_EN, ZERO, OFFSET,
        input  PC, IMEM_READ, INSTR_VALID, STALL
    );

    modport slave (
        input  IMEM_BUSYWAIT, DMEM_BUSYWAIT, JUMP_EN, BRANCH_EN, BNE_EN, ZERO, OFFSET,
        output PC, IMEM_READ, INSTR_VALID, STALL
    );
endinterface

// File: rtl/pc_target_calc.sv
// Combinational sequential-PC and branch/jump target adders (modulo 2^32).
module pc_target_calc
    import pc_seq_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [7:0]  offset_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] target_o
);

    assign pc_plus4_o = pc_i + PC_INCR;
    assign target_o   = pc_plus4_o + offset_to_bytes(offset_i);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute PC sequencer with registered outputs.
// Define PC_SEQ_BNE_EN to enable branch-if-not-equal target selection.
module pc_sequencer
    import pc_seq_pkg::*;
(
    input  logic         CLK,
    input  logic         RESET,
    pc_sequencer_if.slave bus
);

    pc_seq_state_e state_q;
    logic [31:0]   pc_q;
    logic [31:0]   pc_d;
    logic          imem_read_q;
    logic          instr_valid_q;
    logic          stall_q;

    logic [31:0]   pc_plus4;
    logic [31:0]   pc_target;
    logic          take_target;

    pc_target_calc u_target_calc (
        .pc_i       (pc_q),
        .offset_i   (bus.OFFSET),
        .pc_plus4_o (pc_plus4),
        .target_o   (pc_target)
    );

    // Priority: jump, then branch-if-equal, then branch-if-not-equal.
    always_comb begin
        take_target = 1'b0;
        if (bus.JUMP_EN) begin
            take_target = 1'b1;
        end else if (bus.BRANCH_EN) begin
            take_target = bus.ZERO;
`ifdef PC_SEQ_BNE_EN
        end else if (bus.BNE_EN) begin
            take_target = !bus.ZERO;
`else
        end else if (bus.BNE_EN) begin
            take_target = 1'b0;
`endif
        end
        pc_d = take_target ? pc_target : pc_plus4;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= IDLE;
            pc_q          <= PC_RESET_VALUE;
            imem_read_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            stall_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q     <= FETCH;
                    imem_read_q <= 1'b1;
                end
                FETCH: begin
                    if (!bus.IMEM_BUSYWAIT) begin
                        state_q       <= EXEC;
                        imem_read_q   <= 1'b0;
                        instr_valid_q <= 1'b1;
                        stall_q       <= 1'b0;
                    end
                end
                EXEC: begin
                    if (bus.DMEM_BUSYWAIT) begin
                        stall_q <= 1'b1;
                    end else begin
                        pc_q          <= pc_d;
                        state_q       <= FETCH;
                        imem_read_q   <= 1'b1;
                        instr_valid_q <= 1'b0;
                        stall_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    imem_read_q   <= 1'b0;
                    instr_valid_q <= 1'b0;
                    stall_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PC          = pc_q;
    assign bus.IMEM_READ   = imem_read_q;
    assign bus.INSTR_VALID = instr_valid_q;
    assign bus.STALL       = stall_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (honours PC_SEQ_BNE_EN).
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic CLK;
    logic RESET;
    int   n_checks;
    int   n_fail;
    logic [31:0] cur_pc;

`ifdef PC_SEQ_BNE_EN
    localparam logic [31:0] E_BNE     = 32'h0000_002C;
    localparam logic [7:0]  OFF_TO_40 = 8'h00;
`else
    localparam logic [31:0] E_BNE     = 32'h0000_0024;
    localparam logic [7:0]  OFF_TO_40 = 8'h02;
`endif

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Runs one fetch/execute pass starting in FETCH just after an edge.
    task automatic do_instr(input logic j, input logic b, input logic n, input logic z,
                            input logic [7:0] off, input int iwait, input int dwait,
                            input logic [31:0] exp_pc);
        bus.DMEM_BUSYWAIT = 1'b1;
        bus.JUMP_EN       = 1'b1;
        bus.OFFSET        = 8'h55;
        for (int i = 0; i < iwait; i++) begin
            bus.IMEM_BUSYWAIT = 1'b1;
            step();
            chk("fetch_hold_read",  32'(bus.IMEM_READ),   32'd1);
            chk("fetch_hold_valid", 32'(bus.INSTR_VALID), 32'd0);
            chk("fetch_hold_pc",    bus.PC,               cur_pc);
            chk("fetch_hold_stall", 32'(bus.STALL),       32'd0);
        end
        bus.IMEM_BUSYWAIT = 1'b0;
        step();
        chk("exec_valid", 32'(bus.INSTR_VALID), 32'd1);
        chk("exec_read",  32'(bus.IMEM_READ),   32'd0);
        chk("exec_stall", 32'(bus.STALL),       32'd0);
        chk("exec_pc",    bus.PC,               cur_pc);
        bus.IMEM_BUSYWAIT = 1'b1;
        for (int i = 0; i < dwait; i++) begin
            step();
            chk("stall_flag",  32'(bus.STALL),       32'd1);
            chk("stall_pc",    bus.PC,               cur_pc);
            chk("stall_valid", 32'(bus.INSTR_VALID), 32'd1);
        end
        bus.DMEM_BUSYWAIT = 1'b0;
        bus.JUMP_EN       = j;
        bus.BRANCH_EN     = b;
        bus.BNE_EN        = n;
        bus.ZERO          = z;
        bus.OFFSET        = off;
        step();
        chk("next_pc",    bus.PC,               exp_pc);
        chk("next_read",  32'(bus.IMEM_READ),   32'd1);
        chk("next_valid", 32'(bus.INSTR_VALID), 32'd0);
        chk("next_stall", 32'(bus.STALL),       32'd0);
        cur_pc            = exp_pc;
        bus.JUMP_EN       = 1'b0;
        bus.BRANCH_EN     = 1'b0;
        bus.BNE_EN        = 1'b0;
        bus.ZERO          = 1'b0;
        bus.OFFSET        = 8'h00;
        bus.IMEM_BUSYWAIT = 1'b0;
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        cur_pc            = 32'h0;
        RESET             = 1'b1;
        bus.IMEM_BUSYWAIT = 1'b0;
        bus.DMEM_BUSYWAIT = 1'b0;
        bus.JUMP_EN       = 1'b0;
        bus.BRANCH_EN     = 1'b0;
        bus.BNE_EN        = 1'b0;
        bus.ZERO          = 1'b0;
        bus.OFFSET        = 8'h00;

        repeat (3) step();
        chk("rst_pc",    bus.PC,               32'h0);
        chk("rst_read",  32'(bus.IMEM_READ),   32'd0);
        chk("rst_valid", 32'(bus.INSTR_VALID), 32'd0);
        chk("rst_stall", 32'(bus.STALL),       32'd0);

        RESET = 1'b0;
        step();
        chk("first_fetch_read",  32'(bus.IMEM_READ),   32'd1);
        chk("first_fetch_valid", 32'(bus.INSTR_VALID), 32'd0);
        chk("first_fetch_pc",    bus.PC,               32'h0);

        do_instr(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0, 32'h0000_0004);
        do_instr(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3, 0, 32'h0000_0008);
        do_instr(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0, 32'h0000_000C);
        do_instr(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0, 32'h0000_0010);
        do_instr(1'b1, 1'b0, 1'b0, 1'b0, 8'hFE, 0, 0, 32'h0000_000C);
        do_instr(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0, 32'h0000_0010);
        do_instr(1'b0, 1'b1, 1'b0, 1'b0, 8'h03, 0, 0, 32'h0000_0014);
        do_instr(1'b0, 1'b1, 1'b0, 1'b1, 8'h03, 0, 0, 32'h0000_0024);
        do_instr(1'b1, 1'b0, 1'b0, 1'b0, 8'hFE, 1, 0, 32'h0000_0020);
        do_instr(1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 0, 0, E_BNE);
        do_instr(1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 0, 0, E_BNE + 32'h4);
        do_instr(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 2, E_BNE + 32'h8);
        do_instr(1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 0, 0, E_BNE + 32'h10);
        do_instr(1'b1, 1'b0, 1'b0, 1'b0, OFF_TO_40, 0, 0, 32'h0000_0040);

        // Async reset in the middle of a data-memory stall.
        bus.IMEM_BUSYWAIT = 1'b0;
        step();
        chk("pre_rst_valid", 32'(bus.INSTR_VALID), 32'd1);
        bus.DMEM_BUSYWAIT = 1'b1;
        step();
        chk("pre_rst_stall", 32'(bus.STALL), 32'd1);
        chk("pre_rst_pc",    bus.PC,         32'h0000_0040);
        #2;
        RESET = 1'b1;
        #1;
        chk("async_rst_pc",    bus.PC,               32'h0);
        chk("async_rst_read",  32'(bus.IMEM_READ),   32'd0);
        chk("async_rst_valid", 32'(bus.INSTR_VALID), 32'd0);
        chk("async_rst_stall", 32'(bus.STALL),       32'd0);
        repeat (2) step();
        RESET             = 1'b0;
        bus.DMEM_BUSYWAIT = 1'b0;
        step();
        chk("refetch_read", 32'(bus.IMEM_READ), 32'd1);
        chk("refetch_pc",   bus.PC,             32'h0);
        cur_pc = 32'h0;

        do_instr(1'b1, 1'b0, 1'b0, 1'b0, 8'hFE, 0, 0, 32'hFFFF_FFFC);
        do_instr(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
